// File: rtl/fp_stream_pkg.sv
// Shared constants, field positions, FIFO entry layout and FSM encoding for the result streamer.
package fp_stream_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_DOUBLE = 1'b1;

    localparam int unsigned NUM_FLAGS = 4;
    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_INF   = 1;
    localparam int unsigned FLG_NAN   = 2;
    localparam int unsigned FLG_OVF   = 3;

    localparam int unsigned PAYLOAD_W = 64;
    localparam int unsigned BEAT_W    = 32;

    localparam int unsigned SP_EXP_MSB = 30;
    localparam int unsigned SP_EXP_LSB = 23;
    localparam int unsigned SP_MAN_MSB = 22;
    localparam int unsigned DP_EXP_MSB = 62;
    localparam int unsigned DP_EXP_LSB = 52;
    localparam int unsigned DP_MAN_MSB = 51;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    typedef struct packed {
        logic                 mode;
        logic [PAYLOAD_W-1:0] payload;
        logic [NUM_FLAGS-1:0] flags;
    } entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational zero/inf/NaN/overflow classifier for single or double results.
module fp_classify
    import fp_stream_pkg::*;
(
    input  logic                 mode,
    input  logic [62:0]          payload,
    input  logic                 ovf,
    output logic [NUM_FLAGS-1:0] flags_c
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    // Pick the exponent/mantissa fields of the active format and flag special values.
    always_comb begin
        flags_c  = '0;
        exp_zero = 1'b0;
        exp_ones = 1'b0;
        man_zero = 1'b0;
        if (mode == MODE_DOUBLE) begin
            exp_zero = (payload[DP_EXP_MSB:DP_EXP_LSB] == '0);
            exp_ones = &payload[DP_EXP_MSB:DP_EXP_LSB];
            man_zero = (payload[DP_MAN_MSB:0] == '0);
        end else begin
            exp_zero = (payload[SP_EXP_MSB:SP_EXP_LSB] == '0);
            exp_ones = &payload[SP_EXP_MSB:SP_EXP_LSB];
            man_zero = (payload[SP_MAN_MSB:0] == '0);
        end
        flags_c[FLG_ZERO] = exp_zero && man_zero;
        flags_c[FLG_INF]  = exp_ones && man_zero;
        flags_c[FLG_NAN]  = exp_ones && !man_zero;
        flags_c[FLG_OVF]  = ovf;
    end

endmodule

// File: rtl/fp_result_streamer.sv
// Buffers classified FP results in a small FIFO and streams them as 32-bit beats.
module fp_result_streamer
    import fp_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [31:0]          in_result32,
    input  logic [63:0]          in_result64,
    input  logic                 in_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BEAT_W-1:0]    out_data,
    output logic                 out_last,
    output logic [NUM_FLAGS-1:0] out_flags,
    output logic                 out_mode,
    output logic [CNT_W-1:0]     fill_level,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t               mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        nxt_ptr;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 advance;
    logic                 load;
    logic [PAYLOAD_W-1:0] wr_payload;
    logic [NUM_FLAGS-1:0] wr_flags;
    entry_t               head;
    entry_t               nxt;
    entry_t               load_ent;

    state_t               state_q;
    state_t               state_d;
    logic                 valid_d;
    logic [BEAT_W-1:0]    data_d;
    logic                 last_d;
    logic [NUM_FLAGS-1:0] flags_d;
    logic                 mode_d;

    assign in_ready   = (fill_level != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign drop       = in_valid && !in_ready;
    assign wr_payload = (in_mode == MODE_DOUBLE) ? in_result64 : {32'h0, in_result32};
    assign nxt_ptr    = rd_ptr + AW'(1);
    assign head       = mem[rd_ptr];
    assign nxt        = mem[nxt_ptr];

    fp_classify u_classify (
        .mode    (in_mode),
        .payload (wr_payload[62:0]),
        .ovf     (in_overflow),
        .flags_c (wr_flags)
    );

    // FIFO storage; entries need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{mode: in_mode, payload: wr_payload, flags: wr_flags};
        end
    end

    // Pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= nxt_ptr;
            case ({push, pop})
                2'b10:   fill_level <= fill_level + CNT_W'(1);
                2'b01:   fill_level <= fill_level - CNT_W'(1);
                default: fill_level <= fill_level;
            endcase
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Output FSM next state; the head entry stays in the FIFO until its last beat is taken.
    always_comb begin
        state_d  = state_q;
        valid_d  = out_valid;
        data_d   = out_data;
        last_d   = out_last;
        flags_d  = out_flags;
        mode_d   = out_mode;
        pop      = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        load_ent = head;
        case (state_q)
            IDLE: begin
                if (fill_level != '0) load = 1'b1;
            end
            LO: begin
                if (out_ready) begin
                    if (head.mode == MODE_DOUBLE) begin
                        state_d = HI;
                        data_d  = head.payload[63:32];
                        last_d  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            HI: begin
                if (out_ready) advance = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            pop = 1'b1;
            if (fill_level > CNT_W'(1)) begin
                load     = 1'b1;
                load_ent = nxt;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
        if (load) begin
            state_d = LO;
            valid_d = 1'b1;
            data_d  = load_ent.payload[31:0];
            last_d  = (load_ent.mode == MODE_SINGLE);
            flags_d = load_ent.flags;
            mode_d  = load_ent.mode;
        end
    end

    // Output FSM state and registered beat outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_flags <= '0;
            out_mode  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_last  <= last_d;
            out_flags <= flags_d;
            out_mode  <= mode_d;
        end
    end

endmodule

// File: tb/tb_fp_result_streamer.sv
// Directed scoreboard bench for fp_result_streamer.
module tb_fp_result_streamer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  flags;
        logic        mode;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_result32;
    logic [63:0] in_result64;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [3:0]  out_flags;
    logic        out_mode;
    logic [2:0]  fill_level;
    logic [7:0]  drop_cnt;

    beat_t       exp_q[$];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          model_cnt  = 0;
    int          model_drop = 0;
    logic        held_v     = 1'b0;
    beat_t       held_beat;
    logic [3:0]  cur_flags;
    logic [63:0] cur_val;

    always #5 clk = ~clk;

    fp_result_streamer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_result32 (in_result32),
        .in_result64 (in_result64),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_flags   (out_flags),
        .out_mode    (out_mode),
        .fill_level  (fill_level),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // One clock: score the beat/push happening at the coming edge, then step past it.
    task automatic tick();
        beat_t got;
        beat_t exp;
        beat_t b;
        int    pre;
        @(negedge clk);
        if (rst) begin
            pre = model_cnt;
            chk("fill_level", 64'(fill_level), 64'(model_cnt));
            chk("drop_cnt", 64'(drop_cnt), 64'(model_drop));
            if (in_valid) chk("in_ready", 64'(in_ready), 64'(pre != DEPTH));
            got = {out_data, out_last, out_flags, out_mode};
            if (held_v && out_valid) chk("hold_stable", 64'(got), 64'(held_beat));
            held_v    = out_valid && !out_ready;
            held_beat = got;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(got), 64'(0));
                end else begin
                    exp = exp_q.pop_front();
                    chk("beat", 64'(got), 64'(exp));
                    if (exp.last) model_cnt = model_cnt - 1;
                end
            end
            if (in_valid) begin
                if (pre < DEPTH) begin
                    if (in_mode) begin
                        b.data = cur_val[31:0];  b.last = 1'b0; b.flags = cur_flags; b.mode = 1'b1;
                        exp_q.push_back(b);
                        b.data = cur_val[63:32]; b.last = 1'b1;
                        exp_q.push_back(b);
                    end else begin
                        b.data = cur_val[31:0];  b.last = 1'b1; b.flags = cur_flags; b.mode = 1'b0;
                        exp_q.push_back(b);
                    end
                    model_cnt = model_cnt + 1;
                end else if (model_drop < 255) begin
                    model_drop = model_drop + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic m, input logic [63:0] v, input logic ovf, input logic [3:0] f);
        in_mode     = m;
        in_result32 = m ? 32'h0BAD_F00D : v[31:0];
        in_result64 = m ? v : 64'hDEAD_BEEF_DEAD_BEEF;
        in_overflow = ovf;
        cur_val     = v;
        cur_flags   = f;
    endtask

    task automatic push(input logic m, input logic [63:0] v, input logic ovf, input logic [3:0] f);
        set_in(m, v, ovf, f);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wait_valid", 64'(out_valid), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 64'h0, 1'b0, 4'h0);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_flags", 64'(out_flags), 64'(0));
        chk("rst_out_mode", 64'(out_mode), 64'(0));
        chk("rst_fill", 64'(fill_level), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // 1: single, one-cycle latency
        out_ready = 1'b1;
        push(1'b0, 64'h3FC0_0000, 1'b0, 4'b0000);
        chk("t1_lat_n", 64'(out_valid), 64'(0));
        tick();
        chk("t1_lat_n1", 64'(out_valid), 64'(1));
        drain();

        // 2: double infinity, two beats
        push(1'b1, 64'h7FF0_0000_0000_0000, 1'b0, 4'b0010);
        drain();

        // 3: fill with out_ready low, one drop, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 64'h1000_0000 + 64'(i), 1'b0, 4'b0000);
            tick();
        end
        in_valid = 1'b0;
        chk("t3_fill", 64'(fill_level), 64'(4));
        chk("t3_in_ready", 64'(in_ready), 64'(0));
        chk("t3_drop", 64'(drop_cnt), 64'(1));
        out_ready = 1'b1;
        drain();

        // 4: NaN single, then zero with overflow
        push(1'b0, 64'h7FC0_0001, 1'b0, 4'b0100);
        push(1'b0, 64'h0000_0000, 1'b1, 4'b1001);
        drain();

        // extra classes: denormal, negative double zero, double NaN with overflow
        push(1'b0, 64'h0000_0001, 1'b0, 4'b0000);
        push(1'b1, 64'h8000_0000_0000_0000, 1'b0, 4'b0001);
        push(1'b1, 64'hFFF8_0000_0000_0001, 1'b1, 4'b1100);
        drain();

        // 5: out_ready toggling during a double
        out_ready = 1'b0;
        push(1'b1, 64'h4009_21FB_5444_2D18, 1'b0, 4'b0000);
        wait_valid();
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        drain();

        // back-to-back mixed results with simultaneous push and pop; no bubbles
        push(1'b0, 64'h4040_0000, 1'b0, 4'b0000);
        push(1'b1, 64'h3FF0_0000_0000_0001, 1'b0, 4'b0000);
        push(1'b0, 64'hFF80_0000, 1'b0, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_valid", 64'(out_valid), 64'(1));
            tick();
        end
        chk("b2b_done", 64'(exp_q.size()), 64'(0));

        // drop counter saturation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(1'b0, 64'h3F80_0000, 1'b0, 4'b0000);
        repeat (264) tick();
        in_valid = 1'b0;
        chk("sat_drop", 64'(drop_cnt), 64'(255));
        out_ready = 1'b1;
        drain();

        // 6: reset between LO and HI of a double
        out_ready = 1'b0;
        push(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 4'b0000);
        wait_valid();
        out_ready = 1'b1;
        tick();
        chk("t6_in_hi", 64'(out_last), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_out_data", 64'(out_data), 64'(0));
        chk("t6_out_last", 64'(out_last), 64'(0));
        chk("t6_out_flags", 64'(out_flags), 64'(0));
        chk("t6_fill", 64'(fill_level), 64'(0));
        chk("t6_drop", 64'(drop_cnt), 64'(0));
        exp_q.delete();
        model_cnt  = 0;
        model_drop = 0;
        held_v     = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_stale", 64'(out_valid), 64'(0));
        end
        push(1'b0, 64'h4120_0000, 1'b0, 4'b0000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
